// File: rtl/aes_mix_column_serial.sv
// Byte-serial AES MixColumns / InvMixColumns stage.
// Collects four row bytes and registers the mixed (or bypassed) column as four parallel bytes.
module aes_mix_column_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       encrypt,
  input  logic       bypass,
  input  logic [7:0] d_in,
  output logic       col_valid,
  output logic       busy,
  output logic [7:0] d_out0,
  output logic [7:0] d_out1,
  output logic [7:0] d_out2,
  output logic [7:0] d_out3
);

  logic [1:0]      cnt;
  logic [2:0][7:0] byte_buf;
  logic [3:0][7:0] s;
  logic [3:0][7:0] x2;
  logic [3:0][7:0] x4;
  logic [3:0][7:0] x8;
  logic [3:0][7:0] r;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // The fourth byte is taken straight from d_in so a column completes on its last strobe.
  always_comb begin
    s  = {d_in, byte_buf[2], byte_buf[1], byte_buf[0]};
    x2 = '0;
    x4 = '0;
    x8 = '0;
    r  = '0;
    for (int i = 0; i < 4; i++) begin
      x2[i] = xtime(s[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      if (bypass) begin
        r[i] = s[i];
      end else if (encrypt) begin
        r[i] = x2[i] ^ x2[2'(i + 1)] ^ s[2'(i + 1)] ^ s[2'(i + 2)] ^ s[2'(i + 3)];
      end else begin
        r[i] = (x8[i] ^ x4[i] ^ x2[i])
             ^ (x8[2'(i + 1)] ^ x2[2'(i + 1)] ^ s[2'(i + 1)])
             ^ (x8[2'(i + 2)] ^ x4[2'(i + 2)] ^ s[2'(i + 2)])
             ^ (x8[2'(i + 3)] ^ s[2'(i + 3)]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 2'd0;
      byte_buf  <= '0;
      col_valid <= 1'b0;
      busy      <= 1'b0;
      d_out0    <= 8'h00;
      d_out1    <= 8'h00;
      d_out2    <= 8'h00;
      d_out3    <= 8'h00;
    end else if (clr) begin
      cnt       <= 2'd0;
      col_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (en) begin
      if (cnt == 2'd3) begin
        d_out0    <= r[0];
        d_out1    <= r[1];
        d_out2    <= r[2];
        d_out3    <= r[3];
        col_valid <= 1'b1;
        busy      <= 1'b0;
        cnt       <= 2'd0;
      end else begin
        case (cnt)
          2'd0:    byte_buf[0] <= d_in;
          2'd1:    byte_buf[1] <= d_in;
          default: byte_buf[2] <= d_in;
        endcase
        col_valid <= 1'b0;
        busy      <= 1'b1;
        cnt       <= cnt + 2'd1;
      end
    end else begin
      col_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_mix_column_serial.sv
// Self-checking bench for aes_mix_column_serial: directed AES vectors plus random columns
// against a shift-and-reduce GF(2^8) reference model.
module tb_aes_mix_column_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic       encrypt = 1'b1;
  logic       bypass = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic       col_valid, busy;
  logic [7:0] d_out0, d_out1, d_out2, d_out3;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int last_pulse = 0;

  aes_mix_column_serial dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .encrypt(encrypt), .bypass(bypass),
    .d_in(d_in), .col_valid(col_valid), .busy(busy),
    .d_out0(d_out0), .d_out1(d_out1), .d_out2(d_out2), .d_out3(d_out3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Polynomial product then reduction by 0x11B, independent of any xtime chain.
  function automatic logic [7:0] gmul(input logic [7:0] a, input int b);
    int p = 0;
    for (int i = 0; i < 8; i++)
      if ((b >> i) & 1) p = p ^ (int'(a) << i);
    for (int k = 14; k >= 8; k--)
      if ((p >> k) & 1) p = p ^ (32'h11b << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] model(input logic [31:0] col, input logic enc, input logic byp);
    int coef[4];
    logic [7:0] s[4];
    logic [7:0] r[4];
    for (int i = 0; i < 4; i++) s[i] = col[31 - 8*i -: 8];
    if (enc) coef = '{2, 3, 1, 1};
    else     coef = '{14, 11, 13, 9};
    for (int i = 0; i < 4; i++) begin
      r[i] = 8'h00;
      for (int j = 0; j < 4; j++) r[i] = r[i] ^ gmul(s[(i + j) % 4], coef[j]);
      if (byp) r[i] = s[i];
    end
    return {r[0], r[1], r[2], r[3]};
  endfunction

  // Bytes 0..2 are sent with random mode inputs; only byte 3 carries the intended mode.
  task automatic run_col(input logic [31:0] col, input logic enc, input logic byp,
                         input int max_gap, input string tag);
    logic [31:0] exp;
    exp = model(col, enc, byp);
    for (int i = 0; i < 4; i++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin
        en = 1'b0;
        @(posedge clk); #1;
      end
      en   = 1'b1;
      d_in = col[31 - 8*i -: 8];
      if (i < 3) begin
        encrypt = 1'($urandom);
        bypass  = 1'($urandom);
      end else begin
        encrypt = enc;
        bypass  = byp;
      end
      @(posedge clk); #1;
      if (i < 3) begin
        check({tag, "_novalid"}, {31'd0, col_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      end
    end
    en = 1'b0;
    check({tag, "_valid"}, {31'd0, col_valid}, 32'd1);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    check({tag, "_data"}, {d_out0, d_out1, d_out2, d_out3}, exp);
    last_pulse = cyc;
  endtask

  initial begin
    int p1;
    logic [31:0] held;

    #2;
    check("reset_out", {d_out0, d_out1, d_out2, d_out3}, 32'h0);
    check("reset_flags", {30'd0, col_valid, busy}, 32'd0);
    #5 rst = 1'b1;
    @(posedge clk); #1;

    run_col(32'hdb135345, 1'b1, 1'b0, 0, "cipher1");
    check("cipher1_vec", {d_out0, d_out1, d_out2, d_out3}, 32'h8e4da1bc);
    @(posedge clk); #1;
    check("cipher1_pulse_end", {31'd0, col_valid}, 32'd0);
    check("hold", {d_out0, d_out1, d_out2, d_out3}, 32'h8e4da1bc);

    run_col(32'h8e4da1bc, 1'b0, 1'b0, 0, "decipher");
    check("decipher_vec", {d_out0, d_out1, d_out2, d_out3}, 32'hdb135345);
    run_col(32'hf20a225c, 1'b1, 1'b0, 0, "cipher2");
    check("cipher2_vec", {d_out0, d_out1, d_out2, d_out3}, 32'h9fdc589d);

    run_col(32'h01020304, 1'b1, 1'b1, 3, "bypass");
    check("bypass_vec", {d_out0, d_out1, d_out2, d_out3}, 32'h01020304);
    @(posedge clk); #1;
    check("bypass_pulse_end", {31'd0, col_valid}, 32'd0);

    run_col(32'hc6c6c6c6, 1'b1, 1'b0, 0, "b2b_a");
    check("b2b_a_vec", {d_out0, d_out1, d_out2, d_out3}, 32'hc6c6c6c6);
    p1 = last_pulse;
    run_col(32'h2d26314c, 1'b1, 1'b0, 0, "b2b_b");
    check("b2b_b_vec", {d_out0, d_out1, d_out2, d_out3}, 32'h4d7ebdf8);
    check("b2b_spacing", 32'(last_pulse - p1), 32'd4);

    // Abort: two bytes then clr together with en.
    held = {d_out0, d_out1, d_out2, d_out3};
    encrypt = 1'b1; bypass = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en = 1'b1; d_in = 8'h55 + 8'(i);
      @(posedge clk); #1;
    end
    clr = 1'b1; d_in = 8'hee;
    @(posedge clk); #1;
    clr = 1'b0; en = 1'b0;
    check("clr_busy", {31'd0, busy}, 32'd0);
    check("clr_novalid", {31'd0, col_valid}, 32'd0);
    check("clr_hold", {d_out0, d_out1, d_out2, d_out3}, held);
    run_col(32'hdb135345, 1'b1, 1'b0, 0, "after_clr");
    check("after_clr_vec", {d_out0, d_out1, d_out2, d_out3}, 32'h8e4da1bc);

    // Asynchronous reset between edges, mid-column.
    for (int i = 0; i < 2; i++) begin
      en = 1'b1; d_in = 8'h77;
      @(posedge clk); #1;
    end
    en = 1'b0;
    #3 rst = 1'b0;
    #1;
    check("async_rst_out", {d_out0, d_out1, d_out2, d_out3}, 32'h0);
    check("async_rst_flags", {30'd0, col_valid, busy}, 32'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    run_col(32'hdb135345, 1'b1, 1'b0, 1, "after_rst");
    check("after_rst_vec", {d_out0, d_out1, d_out2, d_out3}, 32'h8e4da1bc);

    for (int n = 0; n < 24; n++)
      run_col($urandom, 1'($urandom), ($urandom_range(3, 0) == 0), 2, "random");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
